// File: rtl/fread_arbiter.sv
// fread_arbiter: shares one SPI-flash "fread" request/response stream between
// requester 0 (boot/image loader) and requester 1 (runtime CPU block reader).
// Each grant issues the winner's offset downstream, then steers exactly CHUNK
// response bytes back to that requester before the next arbitration.
// Optional feature macro: FREAD_ARB_RR_EN (round-robin on ties); when it is
// undefined, requester 0 always wins ties.
module fread_arbiter #(
  parameter int CHUNK = 2048,
  parameter int CW    = 12
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [31:0] r0_offset,
  input  logic        r0_valid,
  output logic        r0_ready,
  output logic [7:0]  r0_data,
  output logic        r0_dvalid,
  output logic        r0_done,
  input  logic [31:0] r1_offset,
  input  logic        r1_valid,
  output logic        r1_ready,
  output logic [7:0]  r1_data,
  output logic        r1_dvalid,
  output logic        r1_done,
  output logic [31:0] req_offset,
  output logic        req_valid,
  input  logic        req_ready,
  input  logic [7:0]  resp_data,
  input  logic        resp_valid,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(CHUNK - 1);

  // The byte counter must be able to reach CHUNK-1 without wrapping.
  if (CHUNK > 2**CW || CHUNK < 1) begin : g_bad_chunk
    $error("fread_arbiter: CHUNK must be in 1..2**CW");
  end

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic          owner_q;
  logic          req_valid_q;
  logic [31:0]   req_offset_q;
  logic          owner_d;
  logic          any_req;
  logic          stream_byte;
  logic          last_byte;

`ifdef FREAD_ARB_RR_EN
  logic          last_q;

  // Round-robin pick: a tie goes to whoever was not served last time.
  always_comb begin
    any_req = r0_valid | r1_valid;
    owner_d = r1_valid;
    if (r0_valid && r1_valid) begin
      owner_d = ~last_q;
    end
  end
`else
  // Fixed-priority pick: the loader wins whenever it is asking.
  always_comb begin
    any_req = r0_valid | r1_valid;
    owner_d = ~r0_valid;
  end
`endif

  // A response byte only counts while streaming; strays elsewhere are dropped.
  always_comb begin
    stream_byte = (state_q == STREAM) && resp_valid;
    last_byte   = stream_byte && (count_q == LAST_IDX);
  end

  // Transaction FSM with registered downstream request, owner and byte count.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q      <= IDLE;
      count_q      <= '0;
      owner_q      <= 1'b0;
      req_valid_q  <= 1'b0;
      req_offset_q <= '0;
`ifdef FREAD_ARB_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q      <= owner_d;
            req_offset_q <= owner_d ? r1_offset : r0_offset;
            req_valid_q  <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (req_ready) begin
            req_valid_q <= 1'b0;
            count_q     <= '0;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (last_byte) begin
`ifdef FREAD_ARB_RR_EN
            last_q  <= owner_q;
`endif
            state_q <= IDLE;
          end else if (stream_byte) begin
            count_q <= count_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake and data steering toward the current owner only.
  always_comb begin
    r0_ready   = (state_q == ISSUE) && req_ready && !owner_q;
    r1_ready   = (state_q == ISSUE) && req_ready && owner_q;
    r0_dvalid  = stream_byte && !owner_q;
    r1_dvalid  = stream_byte && owner_q;
    r0_done    = last_byte && !owner_q;
    r1_done    = last_byte && owner_q;
    r0_data    = resp_data;
    r1_data    = resp_data;
    req_valid  = req_valid_q;
    req_offset = req_offset_q;
    busy       = (state_q != IDLE);
    owner      = owner_q;
  end

endmodule

// File: tb/tb_fread_arbiter.sv
// tb_fread_arbiter: table vectors, directed multi-cycle sequences and random
// traffic, all compared each cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_fread_arbiter;

  localparam int CHUNK = 16;
  localparam int CW    = 4;
`ifdef FREAD_ARB_RR_EN
  localparam logic TIE_SECOND_OWNER = 1'b1;
`else
  localparam logic TIE_SECOND_OWNER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetq;
  logic [31:0] r0_offset, r1_offset, req_offset;
  logic        r0_valid, r1_valid, r0_ready, r1_ready;
  logic [7:0]  r0_data, r1_data, resp_data;
  logic        r0_dvalid, r1_dvalid, r0_done, r1_done;
  logic        req_valid, req_ready, resp_valid, busy, owner;

  fread_arbiter #(.CHUNK(CHUNK), .CW(CW)) dut (
    .clk(clk), .resetq(resetq),
    .r0_offset(r0_offset), .r0_valid(r0_valid), .r0_ready(r0_ready),
    .r0_data(r0_data), .r0_dvalid(r0_dvalid), .r0_done(r0_done),
    .r1_offset(r1_offset), .r1_valid(r1_valid), .r1_ready(r1_ready),
    .r1_data(r1_data), .r1_dvalid(r1_dvalid), .r1_done(r1_done),
    .req_offset(req_offset), .req_valid(req_valid), .req_ready(req_ready),
    .resp_data(resp_data), .resp_valid(resp_valid),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0v, r1v;
    logic [31:0] r0off, r1off;
    logic        reqReady, respValid;
    logic [7:0]  respData;
    logic        chk;
    logic        expBusy, expReqValid, expRdy0, expRdy1;
    logic        expDv0, expDv1, expDone0, expDone1;
  } vec_t;

  int testsRun = 0;
  int testsFailed = 0;

  // Transaction-level reference: one outstanding read at a time.
  logic        mInFlight, mAccepted, mOwner, mLast;
  logic [31:0] mOffset;
  int          mDelivered;
  logic        lastRdy0, lastRdy1;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r0v, input logic r1v, input logic [31:0] r0off,
                              input logic [31:0] r1off, input logic reqReady,
                              input logic respValid, input logic [7:0] respData);
    vec_t v;
    v.r0v = r0v; v.r1v = r1v; v.r0off = r0off; v.r1off = r1off;
    v.reqReady = reqReady; v.respValid = respValid; v.respData = respData;
    v.chk = 1'b0;
    v.expBusy = 0; v.expReqValid = 0; v.expRdy0 = 0; v.expRdy1 = 0;
    v.expDv0 = 0; v.expDv1 = 0; v.expDone0 = 0; v.expDone1 = 0;
    return v;
  endfunction

  function automatic vec_t vx(input vec_t vin, input logic b, input logic rv, input logic y0,
                              input logic y1, input logic d0, input logic d1,
                              input logic n0, input logic n1);
    vec_t v = vin;
    v.chk = 1'b1;
    v.expBusy = b; v.expReqValid = rv; v.expRdy0 = y0; v.expRdy1 = y1;
    v.expDv0 = d0; v.expDv1 = d1; v.expDone0 = n0; v.expDone1 = n1;
    return v;
  endfunction

  function automatic logic pickWinner(input logic v0, input logic v1);
`ifdef FREAD_ARB_RR_EN
    if (v0 && v1) return !mLast;
    return v1;
`else
    return !v0;
`endif
  endfunction

  task automatic modelReset();
    mInFlight = 0; mAccepted = 0; mOwner = 0; mLast = 1; mOffset = 0; mDelivered = 0;
  endtask

  task automatic modelClock(input vec_t v);
    if (!mInFlight) begin
      if (v.r0v || v.r1v) begin
        mOwner    = pickWinner(v.r0v, v.r1v);
        mOffset   = mOwner ? v.r1off : v.r0off;
        mInFlight = 1;
        mAccepted = 0;
      end
    end else if (!mAccepted) begin
      if (v.reqReady) begin
        mAccepted  = 1;
        mDelivered = 0;
      end
    end else if (v.respValid) begin
      mDelivered++;
      if (mDelivered == CHUNK) begin
        mInFlight = 0;
        mLast     = mOwner;
      end
    end
  endtask

  task automatic checkOutput(input vec_t v);
    logic eRdy0, eRdy1, eDv0, eDv1, eDn0, eDn1;
    eRdy0 = mInFlight && !mAccepted && v.reqReady && !mOwner;
    eRdy1 = mInFlight && !mAccepted && v.reqReady && mOwner;
    eDv0  = mInFlight && mAccepted && v.respValid && !mOwner;
    eDv1  = mInFlight && mAccepted && v.respValid && mOwner;
    eDn0  = eDv0 && (mDelivered == CHUNK - 1);
    eDn1  = eDv1 && (mDelivered == CHUNK - 1);
    lastRdy0 = eRdy0;
    lastRdy1 = eRdy1;
    checkField("r0_ready", 32'(r0_ready), 32'(eRdy0));
    checkField("r1_ready", 32'(r1_ready), 32'(eRdy1));
    checkField("r0_dvalid", 32'(r0_dvalid), 32'(eDv0));
    checkField("r1_dvalid", 32'(r1_dvalid), 32'(eDv1));
    checkField("r0_done", 32'(r0_done), 32'(eDn0));
    checkField("r1_done", 32'(r1_done), 32'(eDn1));
    checkField("r0_data", 32'(r0_data), 32'(v.respData));
    checkField("r1_data", 32'(r1_data), 32'(v.respData));
    checkField("req_valid", 32'(req_valid), 32'(mInFlight && !mAccepted));
    checkField("req_offset", req_offset, mOffset);
    checkField("busy", 32'(busy), 32'(mInFlight));
    checkField("owner", 32'(owner), 32'(mOwner));
    if (v.chk) begin
      checkField("vecBusy", 32'(busy), 32'(v.expBusy));
      checkField("vecReqValid", 32'(req_valid), 32'(v.expReqValid));
      checkField("vecReady0", 32'(r0_ready), 32'(v.expRdy0));
      checkField("vecReady1", 32'(r1_ready), 32'(v.expRdy1));
      checkField("vecDvalid0", 32'(r0_dvalid), 32'(v.expDv0));
      checkField("vecDvalid1", 32'(r1_dvalid), 32'(v.expDv1));
      checkField("vecDone0", 32'(r0_done), 32'(v.expDone0));
      checkField("vecDone1", 32'(r1_done), 32'(v.expDone1));
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    r0_valid = v.r0v; r1_valid = v.r1v; r0_offset = v.r0off; r1_offset = v.r1off;
    req_ready = v.reqReady; resp_valid = v.respValid; resp_data = v.respData;
    @(negedge clk);
    checkOutput(v);
    @(posedge clk);
    modelClock(v);
    #1;
  endtask

  task automatic pulseReset();
    vec_t v;
    v = vx(mk(0, 0, 0, 0, 0, 0, 8'h00), 0, 0, 0, 0, 0, 0, 0, 0);
    r0_valid = 0; r1_valid = 0; r0_offset = 0; r1_offset = 0;
    req_ready = 0; resp_valid = 0; resp_data = 0;
    resetq = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput(v);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetq = 1'b1;
  endtask

  // Streams one full chunk to the given owner while holding the other inputs.
  task automatic streamChunk(input logic own, input logic h0, input logic h1,
                             input logic [31:0] o0, input logic [31:0] o1);
    for (int i = 0; i < CHUNK; i++) begin
      applyStimulus(vx(mk(h0, h1, o0, o1, 0, 1, 8'(i + 8'h40)), 1, 0, 0, 0,
                       !own, own, !own && (i == CHUNK - 1), own && (i == CHUNK - 1)));
    end
  endtask

  vec_t tbl[7];

  initial begin
    logic        r0vS, r1vS;
    logic [31:0] r0offS, r1offS;

    resetq = 1'b0;
    pulseReset();

    // Stray bytes in IDLE/ISSUE, lone r0 request at offset 0, start of stream.
    tbl[0] = vx(mk(0, 0, 0, 0, 0, 1, 8'h11), 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = vx(mk(1, 0, 0, 0, 0, 0, 8'h00), 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = vx(mk(1, 0, 0, 0, 0, 1, 8'h22), 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[3] = vx(mk(1, 0, 0, 0, 1, 0, 8'h00), 1, 1, 1, 0, 0, 0, 0, 0);
    tbl[4] = vx(mk(0, 0, 0, 0, 0, 1, 8'h33), 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[5] = vx(mk(0, 0, 0, 0, 0, 0, 8'h00), 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[6] = vx(mk(0, 1, 0, 32'h1000, 0, 1, 8'h44), 1, 0, 0, 0, 1, 0, 0, 0);
    foreach (tbl[i]) applyStimulus(tbl[i]);
    for (int i = 2; i < CHUNK; i++) begin
      applyStimulus(vx(mk(0, 1, 0, 32'h1000, 0, 1, 8'(i)), 1, 0, 0, 0, 1, 0, i == CHUNK - 1, 0));
    end
    // One idle cycle after done, then the waiting r1 request appears.
    applyStimulus(vx(mk(0, 1, 0, 32'h1000, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(vx(mk(0, 1, 0, 32'h1000, 0, 0, 0), 1, 1, 0, 0, 0, 0, 0, 0));
    checkField("r1GrantOwner", 32'(owner), 32'd1);
    checkField("r1GrantOffset", req_offset, 32'h1000);
    applyStimulus(vx(mk(0, 1, 0, 32'h1000, 1, 0, 0), 1, 1, 0, 1, 0, 0, 0, 0));
    streamChunk(1'b1, 0, 0, 0, 0);

    // Both requesters held from reset: r0 first, second grant depends on mode.
    pulseReset();
    applyStimulus(vx(mk(1, 1, 32'h800, 32'h1000, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0));
    checkField("tieFirstOwner", 32'(owner), 32'd0);
    checkField("tieFirstOffset", req_offset, 32'h800);
    applyStimulus(vx(mk(1, 1, 32'h800, 32'h1000, 1, 0, 0), 1, 1, 1, 0, 0, 0, 0, 0));
    streamChunk(1'b0, 1, 1, 32'h800, 32'h1000);
    applyStimulus(vx(mk(1, 1, 32'h800, 32'h1000, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0));
    checkField("tieSecondOwner", 32'(owner), 32'(TIE_SECOND_OWNER));
    checkField("tieSecondOffset", req_offset, TIE_SECOND_OWNER ? 32'h1000 : 32'h800);
    applyStimulus(mk(1, 1, 32'h800, 32'h1000, 1, 0, 0));
    streamChunk(TIE_SECOND_OWNER, 0, 0, 0, 0);

    // Reset in the middle of an r1 stream, then a clean r0 transaction.
    pulseReset();
    applyStimulus(mk(0, 1, 0, 32'h2000, 0, 0, 0));
    applyStimulus(vx(mk(0, 1, 0, 32'h2000, 1, 0, 0), 1, 1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < CHUNK - 6; i++) begin
      applyStimulus(vx(mk(0, 0, 0, 0, 0, 1, 8'(i)), 1, 0, 0, 0, 0, 1, 0, 0));
    end
    pulseReset();
    applyStimulus(vx(mk(1, 0, 32'h300, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(vx(mk(1, 0, 32'h300, 0, 1, 0, 0), 1, 1, 1, 0, 0, 0, 0, 0));
    streamChunk(1'b0, 0, 0, 0, 0);

    // Long stall on req_ready: request must stay stable and unacknowledged.
    pulseReset();
    applyStimulus(mk(1, 0, 32'hABCD, 0, 0, 0, 0));
    for (int i = 0; i < 100; i++) begin
      applyStimulus(vx(mk(1, 0, 32'hABCD, 0, 0, 1'($urandom), 8'($urandom)), 1, 1, 0, 0, 0, 0, 0, 0));
    end
    applyStimulus(vx(mk(1, 0, 32'hABCD, 0, 1, 0, 0), 1, 1, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8 * CHUNK && mInFlight; i++) begin
      applyStimulus(mk(0, 0, 0, 0, 0, 1'($urandom), 8'($urandom)));
    end
    checkField("stallDrained", 32'(mInFlight), 32'd0);

    // Random traffic against the model; requests held until accepted.
    r0vS = 0; r1vS = 0; r0offS = 0; r1offS = 0;
    lastRdy0 = 0; lastRdy1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (lastRdy0) r0vS = 0;
      if (lastRdy1) r1vS = 0;
      if (!r0vS && $urandom_range(3) == 0) begin r0vS = 1; r0offS = $urandom; end
      if (!r1vS && $urandom_range(3) == 0) begin r1vS = 1; r1offS = $urandom; end
      if (r0vS && mInFlight && !mAccepted && !mOwner && $urandom_range(31) == 0) r0vS = 0;
      if (r1vS && mInFlight && !mAccepted && mOwner && $urandom_range(31) == 0) r1vS = 0;
      applyStimulus(mk(r0vS, r1vS, r0offS, r1offS, $urandom_range(2) == 0,
                       1'($urandom_range(1)), 8'($urandom)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
